// File: rtl/judge_grant_sequencer.sv
// Turns a one-hot judge grant into a timed bus lease (OWN), followed by an
// optional cooldown (GAP); flags multi-hot grants and counts completed leases.
module judge_grant_sequencer #(
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned IDLE_GAP  = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gnt3,
   input  logic             gnt2,
   input  logic             gnt1,
   input  logic             gnt0,
   input  logic             xfer_last,
   output logic             owner_vld,
   output logic [1:0]       owner_id,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             bus_busy,
   output logic             lease_done,
   output logic             grant_err,
   output logic [15:0]      lease_cnt
);

   localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t             state, state_d;
   logic [3:0]         gnt;
   logic               one_hot, multi_hot, terminal, gap_end;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
   logic [1:0]         grant_idx;

   logic               owner_vld_d, bus_busy_d, lease_done_d, grant_err_d;
   logic [1:0]         owner_id_d;
   logic [CNT_W-1:0]   beat_cnt_d;
   logic [15:0]        lease_cnt_d;

   assign gnt       = {gnt3, gnt2, gnt1, gnt0};
   assign multi_hot = (gnt & (gnt - 4'd1)) != '0;
   assign one_hot   = (gnt != '0) && !multi_hot;
   assign terminal  = (state == OWN) &&
                      (xfer_last || (beat_cnt == CNT_W'(BURST_LEN - 1)));
   assign gap_end   = (gap_cnt == GAP_W'(IDLE_GAP - 1));

   always_comb begin
      grant_idx = 2'd0;
      unique case (1'b1)
         gnt[3]:  grant_idx = 2'd3;
         gnt[2]:  grant_idx = 2'd2;
         gnt[1]:  grant_idx = 2'd1;
         default: grant_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (one_hot)  state_d = OWN;
         OWN:     if (terminal) state_d = (IDLE_GAP > 0) ? GAP : IDLE;
         GAP:     if (gap_end)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the current and next state.
   always_comb begin
      owner_vld_d  = (state_d == OWN);
      bus_busy_d   = (state_d != IDLE);
      lease_done_d = terminal;
      owner_id_d   = owner_id;
      beat_cnt_d   = '0;
      grant_err_d  = grant_err;
      lease_cnt_d  = lease_cnt;
      gap_cnt_d    = '0;
      case (state)
         IDLE: begin
            if (one_hot)   owner_id_d  = grant_idx;
            if (multi_hot) grant_err_d = 1'b1;
         end
         OWN: begin
            if (!terminal) beat_cnt_d = beat_cnt + CNT_W'(1);
            if (terminal && (lease_cnt != '1)) lease_cnt_d = lease_cnt + 16'd1;
         end
         GAP:     gap_cnt_d = gap_cnt + GAP_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_vld  <= 1'b0;
         owner_id   <= '0;
         beat_cnt   <= '0;
         bus_busy   <= 1'b0;
         lease_done <= 1'b0;
         grant_err  <= 1'b0;
         lease_cnt  <= '0;
         gap_cnt    <= '0;
      end else begin
         owner_vld  <= owner_vld_d;
         owner_id   <= owner_id_d;
         beat_cnt   <= beat_cnt_d;
         bus_busy   <= bus_busy_d;
         lease_done <= lease_done_d;
         grant_err  <= grant_err_d;
         lease_cnt  <= lease_cnt_d;
         gap_cnt    <= gap_cnt_d;
      end
   end

endmodule

// File: tb/tb_judge_grant_sequencer.sv
// Directed bench for judge_grant_sequencer: default instance plus a
// BURST_LEN=2 / IDLE_GAP=0 instance for back-to-back leases.
module tb_judge_grant_sequencer;

   logic        clk, rst;
   logic        gnt3, gnt2, gnt1, gnt0, xfer_last;
   logic        owner_vld, bus_busy, lease_done, grant_err;
   logic [1:0]  owner_id;
   logic [7:0]  beat_cnt;
   logic [15:0] lease_cnt;
   logic        u1_vld, u1_busy, u1_done, u1_err;
   logic [1:0]  u1_id;
   logic [7:0]  u1_beat;
   logic [15:0] u1_cnt;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   judge_grant_sequencer dut (
      .clk(clk), .rst(rst), .gnt3(gnt3), .gnt2(gnt2), .gnt1(gnt1), .gnt0(gnt0),
      .xfer_last(xfer_last), .owner_vld(owner_vld), .owner_id(owner_id),
      .beat_cnt(beat_cnt), .bus_busy(bus_busy), .lease_done(lease_done),
      .grant_err(grant_err), .lease_cnt(lease_cnt)
   );

   judge_grant_sequencer #(.BURST_LEN(2), .IDLE_GAP(0), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .gnt3(gnt3), .gnt2(gnt2), .gnt1(gnt1), .gnt0(gnt0),
      .xfer_last(xfer_last), .owner_vld(u1_vld), .owner_id(u1_id),
      .beat_cnt(u1_beat), .bus_busy(u1_busy), .lease_done(u1_done),
      .grant_err(u1_err), .lease_cnt(u1_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".vld"},  32'(owner_vld),  32'd0);
      check({tag, ".id"},   32'(owner_id),   32'd0);
      check({tag, ".beat"}, 32'(beat_cnt),   32'd0);
      check({tag, ".busy"}, 32'(bus_busy),   32'd0);
      check({tag, ".done"}, 32'(lease_done), 32'd0);
      check({tag, ".err"},  32'(grant_err),  32'd0);
      check({tag, ".cnt"},  32'(lease_cnt),  32'd0);
   endtask

   initial begin
      rst = 1'b1; xfer_last = 1'b0;
      gnt3 = 1'b0; gnt2 = 1'b0; gnt1 = 1'b0; gnt0 = 1'b1;
      #1 rst = 1'b0;
      #1 check_all_zero("rst_async");
      tick(2);
      check_all_zero("rst_held");
      rst = 1'b1;
      tick(1);
      check("t1.vld", 32'(owner_vld), 32'd1);
      check("t1.id",  32'(owner_id),  32'd0);
      gnt0 = 1'b0;
      tick(3);
      check("t1.beat3", 32'(beat_cnt), 32'd3);
      tick(1);
      check("t1.done", 32'(lease_done), 32'd1);
      check("t1.cnt",  32'(lease_cnt),  32'd1);
      tick(1);

      // full burst
      gnt2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         gnt2 = 1'b0;
         check("t2.vld",  32'(owner_vld), 32'd1);
         check("t2.id",   32'(owner_id),  32'd2);
         check("t2.beat", 32'(beat_cnt),  32'(i));
         check("t2.busy", 32'(bus_busy),  32'd1);
         check("t2.nodone", 32'(lease_done), 32'd0);
      end
      tick(1);
      check("t2.vld_off", 32'(owner_vld),  32'd0);
      check("t2.done",    32'(lease_done), 32'd1);
      check("t2.gapbusy", 32'(bus_busy),   32'd1);
      check("t2.beat0",   32'(beat_cnt),   32'd0);
      check("t2.cnt",     32'(lease_cnt),  32'd2);
      check("t2.id_hold", 32'(owner_id),   32'd2);
      tick(1);
      check("t2.idle_busy", 32'(bus_busy),   32'd0);
      check("t2.done_off",  32'(lease_done), 32'd0);

      // early release
      gnt1 = 1'b1;
      tick(1);
      gnt1 = 1'b0;
      check("t3.id", 32'(owner_id), 32'd1);
      tick(1);
      check("t3.beat1", 32'(beat_cnt), 32'd1);
      xfer_last = 1'b1;
      tick(1);
      xfer_last = 1'b0;
      check("t3.vld_off", 32'(owner_vld),  32'd0);
      check("t3.done",    32'(lease_done), 32'd1);
      check("t3.cnt",     32'(lease_cnt),  32'd3);
      check("t3.busy",    32'(bus_busy),   32'd1);
      tick(1);
      check("t3.done_once", 32'(lease_done), 32'd0);
      check("t3.idle",      32'(bus_busy),   32'd0);
      xfer_last = 1'b1;
      tick(1);
      xfer_last = 1'b0;
      check("t3.xl_idle_done", 32'(lease_done), 32'd0);
      check("t3.xl_idle_cnt",  32'(lease_cnt),  32'd3);

      // busy masking: gnt3 held through OWN and GAP, accepted only once IDLE
      gnt0 = 1'b1;
      tick(1);
      gnt0 = 1'b0; gnt3 = 1'b1;
      check("t4.id0", 32'(owner_id), 32'd0);
      tick(3);
      check("t4.id_keep", 32'(owner_id), 32'd0);
      check("t4.beat3",   32'(beat_cnt), 32'd3);
      tick(1);
      check("t4.done", 32'(lease_done), 32'd1);
      check("t4.cnt",  32'(lease_cnt),  32'd4);
      tick(1);
      check("t4.gap_exit_vld", 32'(owner_vld), 32'd0);
      check("t4.gap_exit_busy", 32'(bus_busy), 32'd0);
      check("t4.err", 32'(grant_err), 32'd0);
      tick(1);
      gnt3 = 1'b0;
      check("t4.vld3", 32'(owner_vld), 32'd1);
      check("t4.id3",  32'(owner_id),  32'd3);
      tick(4);
      check("t4.cnt2", 32'(lease_cnt), 32'd5);
      tick(1);

      // illegal multi-hot grant
      gnt0 = 1'b1; gnt1 = 1'b1;
      tick(1);
      gnt0 = 1'b0; gnt1 = 1'b0;
      check("t5.err",  32'(grant_err), 32'd1);
      check("t5.vld",  32'(owner_vld), 32'd0);
      check("t5.busy", 32'(bus_busy),  32'd0);
      tick(1);
      check("t5.vld2", 32'(owner_vld), 32'd0);
      gnt2 = 1'b1;
      tick(1);
      gnt2 = 1'b0;
      check("t5.legal_vld", 32'(owner_vld), 32'd1);
      check("t5.legal_id",  32'(owner_id),  32'd2);
      tick(4);
      check("t5.cnt", 32'(lease_cnt), 32'd6);
      tick(1);
      check("t5.sticky", 32'(grant_err), 32'd1);

      // mid-lease reset
      gnt1 = 1'b1;
      tick(1);
      gnt1 = 1'b0;
      tick(2);
      check("t6.beat2", 32'(beat_cnt), 32'd2);
      #2 rst = 1'b0;
      #1 check_all_zero("t6.async");
      tick(1);
      check("t6.nodone", 32'(lease_done), 32'd0);
      check("t6.cnt0",   32'(lease_cnt),  32'd0);
      rst = 1'b1;
      tick(1);

      // lease counter saturation
      force dut.lease_cnt = 16'hFFFE;
      #1 release dut.lease_cnt;
      gnt0 = 1'b1;
      tick(1);
      gnt0 = 1'b0;
      tick(4);
      check("t7.cnt_ffff", 32'(lease_cnt), 32'hFFFF);
      tick(1);
      gnt0 = 1'b1;
      tick(1);
      gnt0 = 1'b0;
      tick(4);
      check("t7.sat_done", 32'(lease_done), 32'd1);
      check("t7.sat",      32'(lease_cnt),  32'hFFFF);
      tick(1);

      // IDLE_GAP=0: grant right after lease_done starts a new lease
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      gnt0 = 1'b1;
      tick(1);
      check("t8.vld",   32'(u1_vld),  32'd1);
      tick(1);
      check("t8.beat1", 32'(u1_beat), 32'd1);
      tick(1);
      check("t8.done",  32'(u1_done), 32'd1);
      check("t8.vld0",  32'(u1_vld),  32'd0);
      check("t8.busy0", 32'(u1_busy), 32'd0);
      check("t8.cnt",   32'(u1_cnt),  32'd1);
      tick(1);
      gnt0 = 1'b0;
      check("t8.relvld",  32'(u1_vld),  32'd1);
      check("t8.reldone", 32'(u1_done), 32'd0);
      check("t8.relbeat", 32'(u1_beat), 32'd0);
      check("t8.id",      32'(u1_id),   32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
